// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the pipeline front end.
//   NOP_INSTR        : instruction presented on a bubble (addi x0,x0,0)
//   RESET_PC_DEFAULT : default PC loaded on reset
//   fetch_state_t    : fetch request FSM states
//   pc_plus4()       : sequential PC increment, wraps modulo 2^32
package rv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,  // free to issue a request
    FETCH_WAIT = 2'd1,  // request granted, response pending
    FETCH_KILL = 2'd2   // response pending but already known to be wrong-path
  } fetch_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with flush/stall priority, used between Fetch and
// Decode (and intended for reuse by the later stage registers).
//   clk, rst            : clock, synchronous active-high reset
//   flush               : load a bubble (valid=0, instr=NOP_INSTR)
//   stall               : hold the current contents
//   load_valid          : load_* carry a real instruction this cycle
//   load_instr/pc/pc_plus4 : incoming payload
//   valid, instr, pc, pc_plus4 : registered contents
// Priority: rst > flush > stall > load > bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load_valid,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_pc_plus4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (flush) begin
      // PC fields are left as-is; valid=0 marks them as meaningless.
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (!stall) begin
      if (load_valid) begin
        valid    <= 1'b1;
        instr    <= load_instr;
        pc       <= load_pc;
        pc_plus4 <= load_pc_plus4;
      end else begin
        valid <= 1'b0;
        instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding instruction
// memory request FSM, one-entry hold buffer for responses that arrive
// while Decode is stalled, and the IF/ID register.
//   clk, rst                : clock, synchronous active-high reset
//   stall_F, stall_D, flush_D : hazard unit controls
//   PC_src_D, PC_target_D   : redirect from Decode
//   imem_req/imem_addr      : fetch request (word aligned address)
//   imem_gnt                : request accepted this cycle
//   imem_rvalid/imem_rdata  : instruction response
//   instr_D, PC_D, PC_plus4_D, valid_D : IF/ID register contents
//   fetch_wait_F            : a request is outstanding (WAIT or KILL)
//   bubble_cnt              : saturating count of non-flush bubbles loaded
//   fetch_state_dbg         : current FSM state
//
// Memory handshake: a request transfers on a cycle where imem_req and
// imem_gnt are both high; imem_req may drop without a grant. The response
// is a single-cycle imem_rvalid pulse with imem_rdata and cannot be
// back-pressured, which is why a hold buffer catches it when Decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv_pipe_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        PC_src_D,
  input  logic [31:0] PC_target_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_plus4_D,
  output logic        valid_D,
  output logic        fetch_wait_F,
  output logic [15:0] bubble_cnt,
  output logic [1:0]  fetch_state_dbg
);
  import rv_pipe_pkg::*;

  fetch_state_t state, state_next;

  logic [31:0] pc_f;
  logic [31:0] req_pc;       // PC of the outstanding request
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        grant;
  logic        live_rsp;
  logic        use_hold;
  logic        if_load_valid;
  logic        bubble_load;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  // No new request while a held instruction is still waiting for Decode,
  // and none on a redirect cycle since pc_f is about to change.
  assign imem_req  = (state == FETCH_REQ) && !stall_F && !PC_src_D && !hold_valid;
  assign imem_addr = pc_f;
  assign grant     = imem_req && imem_gnt;

  // A response is only useful in WAIT and when not overtaken by a
  // same-cycle redirect or flush.
  assign live_rsp = (state == FETCH_WAIT) && imem_rvalid && !PC_src_D && !flush_D;

  // A redirect makes the held instruction wrong-path; drop it instead of
  // forwarding it in the same cycle the buffer is cleared.
  assign use_hold      = hold_valid && !PC_src_D;
  assign if_load_valid = use_hold || live_rsp;
  assign if_instr      = use_hold ? hold_instr : imem_rdata;
  assign if_pc         = use_hold ? hold_pc : req_pc;
  assign bubble_load   = !flush_D && !stall_D && !if_load_valid;

  assign fetch_wait_F    = (state == FETCH_WAIT) || (state == FETCH_KILL);
  assign fetch_state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      FETCH_REQ: begin
        if (grant) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid)   state_next = FETCH_REQ;
        else if (PC_src_D) state_next = FETCH_KILL;
      end
      FETCH_KILL: begin
        if (imem_rvalid) state_next = FETCH_REQ;
      end
      default: state_next = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_REQ;
    end else begin
      state <= state_next;
    end
  end

  // PC register; a redirect wins over the sequential increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f   <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (PC_src_D) begin
      pc_f <= PC_target_D;
    end else if (grant) begin
      pc_f   <= pc_plus4(pc_f);
      req_pc <= pc_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
    end else if (PC_src_D) begin
      hold_valid <= 1'b0;
    end else if (live_rsp && stall_D) begin
      hold_valid <= 1'b1;
      hold_instr <= imem_rdata;
      hold_pc    <= req_pc;
    end else if (use_hold && !flush_D && !stall_D) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble_load && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush_D),
    .stall        (stall_D),
    .load_valid   (if_load_valid),
    .load_instr   (if_instr),
    .load_pc      (if_pc),
    .load_pc_plus4(pc_plus4(if_pc)),
    .valid        (valid_D),
    .instr        (instr_D),
    .pc           (PC_D),
    .pc_plus4     (PC_plus4_D)
  );

endmodule
